// File: rtl/lift_car_fsm.sv
// Purpose : lift car controller - slow-clock tick resync, floor call latch, SCAN car FSM, door timer.
// Latency : tick 3 CLK edges after clk_slow rises; calls visible on req_pending 1 cycle after sampling.
// Backpressure: none; calls are level/pulse inputs absorbed into req_pending every cycle.
// Option  : define LIFT_DOOR_HOLD_EN to let a current-floor call during DOOR restart the door timer.
module lift_car_fsm #(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 3
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               clk_slow,
    input  logic [FLOORS-1:0]  call_req,
    output logic [FLOORS-1:0]  req_pending,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam logic [3:0]         MOVE_LIM  = 4'(MOVE_TICKS);
    localparam logic [3:0]         DOOR_LIM  = 4'(DOOR_TICKS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

    state_t cur_state;
    state_t nxt_state;

    // tick resynchroniser
    logic slow_s1;
    logic slow_s2;
    logic slow_prev;
    logic tick;

    // datapath registers and their next values
    logic [3:0]         tick_cnt;
    logic [3:0]         nxt_cnt;
    logic [FLOOR_W-1:0] nxt_floor;
    logic               nxt_dir;
    logic               arrived;
    logic               nxt_arrived;
    logic               clr_here;
    logic [FLOORS-1:0]  nxt_req;

    // request analysis
    logic [FLOORS-1:0]  eff_req;
    logic [FLOORS-1:0]  floor_oh;
    logic               here;
    logic               above;
    logic               below;
    logic               ahead;
    logic               behind;

    assign state = cur_state;

    // Resynchronise clk_slow and emit a one-cycle registered tick on its rising edge.
    // Flops reset to 1 so a high clk_slow at reset release is not seen as an edge.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            slow_s1   <= 1'b1;
            slow_s2   <= 1'b1;
            slow_prev <= 1'b1;
            tick      <= 1'b0;
        end else begin
            slow_s1   <= clk_slow;
            slow_s2   <= slow_s1;
            slow_prev <= slow_s2;
            tick      <= slow_s2 & ~slow_prev;
        end
    end

    // Decode where outstanding requests sit relative to the car. Incoming calls are
    // folded in so a call at the current floor opens the door without ever latching.
    always_comb begin
        eff_req  = req_pending | call_req;
        floor_oh = '0;
        floor_oh[floor] = 1'b1;
        here  = eff_req[floor];
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (eff_req[i]) begin
                if (i > int'(floor)) above = 1'b1;
                if (i < int'(floor)) below = 1'b1;
            end
        end
        ahead  = dir_up ? above : below;
        behind = dir_up ? below : above;
    end

    // State register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic: SCAN car decisions, floor stepping and shared tick counter.
    always_comb begin
        nxt_state   = cur_state;
        nxt_floor   = floor;
        nxt_dir     = dir_up;
        nxt_cnt     = tick_cnt;
        nxt_arrived = 1'b0;
        clr_here    = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                nxt_cnt = '0;
                if (here) begin
                    nxt_state = ST_DOOR;
                    clr_here  = 1'b1;
                end else if (ahead) begin
                    nxt_state = ST_MOVE;
                end else if (behind) begin
                    nxt_state = ST_MOVE;
                    nxt_dir   = ~dir_up;
                end
            end
            ST_MOVE: begin
                // Arrival is judged the cycle after the floor step, at the new floor.
                if (arrived && here) begin
                    nxt_state = ST_DOOR;
                    clr_here  = 1'b1;
                    nxt_cnt   = '0;
                end else if (arrived && !ahead) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end else if (tick) begin
                    if (4'(tick_cnt + 4'd1) >= MOVE_LIM) begin
                        nxt_cnt     = '0;
                        nxt_arrived = 1'b1;
                        // Saturate at the shaft ends; arrival logic then drops to IDLE.
                        if (dir_up && floor != TOP_FLOOR) begin
                            nxt_floor = floor + FLOOR_W'(1);
                        end else if (!dir_up && floor != '0) begin
                            nxt_floor = floor - FLOOR_W'(1);
                        end
                    end else begin
                        nxt_cnt = 4'(tick_cnt + 4'd1);
                    end
                end
            end
            ST_DOOR: begin
                if (tick) begin
                    if (4'(tick_cnt + 4'd1) >= DOOR_LIM) begin
                        nxt_state = ST_IDLE;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = 4'(tick_cnt + 4'd1);
                    end
                end
`ifdef LIFT_DOOR_HOLD_EN
                // A re-press at this floor restarts the full door interval.
                if (call_req[floor]) begin
                    nxt_state = ST_DOOR;
                    nxt_cnt   = '0;
                end
`endif
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Latch new calls; the current floor's bit is dropped while the door is open
    // and on the cycle the door opens, so a simultaneous call there is absorbed.
    always_comb begin
        nxt_req = req_pending | call_req;
        if (cur_state == ST_DOOR || clr_here) begin
            nxt_req = nxt_req & ~floor_oh;
        end
    end

    // Datapath registers: floor, direction, tick counter, arrival flag, pending calls.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            floor       <= '0;
            dir_up      <= 1'b1;
            tick_cnt    <= '0;
            arrived     <= 1'b0;
            req_pending <= '0;
        end else begin
            floor       <= nxt_floor;
            dir_up      <= nxt_dir;
            tick_cnt    <= nxt_cnt;
            arrived     <= nxt_arrived;
            req_pending <= nxt_req;
        end
    end

    // Output decode from the current state.
    always_comb begin
        moving    = (cur_state == ST_MOVE);
        door_open = (cur_state == ST_DOOR);
    end

endmodule

// File: tb/tb_lift_car_fsm.sv
// Purpose : directed bench for lift_car_fsm (FLOORS=8, MOVE_TICKS=2, DOOR_TICKS=3).
// Latency : clk_slow driven by hand with a 20-CLK period; checks sampled 1 time unit after CLK rise.
// Backpressure: n/a; honours LIFT_DOOR_HOLD_EN for the door-hold expectation.
module tb_lift_car_fsm;

    logic       CLK      = 1'b0;
    logic       reset    = 1'b0;
    logic       clk_slow = 1'b0;
    logic [7:0] call_req = 8'h00;
    logic [7:0] req_pending;
    logic [2:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [1:0] state;

    int n_checks = 0;
    int n_err    = 0;

    lift_car_fsm #(
        .FLOORS     (8),
        .FLOOR_W    (3),
        .MOVE_TICKS (2),
        .DOOR_TICKS (3)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .clk_slow    (clk_slow),
        .call_req    (call_req),
        .req_pending (req_pending),
        .floor       (floor),
        .dir_up      (dir_up),
        .moving      (moving),
        .door_open   (door_open),
        .state       (state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n CLK edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One full clk_slow period (20 CLK); its tick is fully consumed on return.
    task automatic slow_tick();
        clk_slow = 1'b1;
        step(10);
        clk_slow = 1'b0;
        step(10);
    endtask

    task automatic pulse_call(input int f);
        call_req    = 8'h00;
        call_req[f] = 1'b1;
        step(1);
        call_req    = 8'h00;
    endtask

    initial begin
        // Reset held with clk_slow toggling
        step(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_floor", 32'(floor), 32'd0);
        check("rst_dir",   32'(dir_up), 32'd1);
        check("rst_pend",  32'(req_pending), 32'h00);
        check("rst_mov",   32'(moving), 32'd0);
        check("rst_door",  32'(door_open), 32'd0);
        clk_slow = 1'b1; step(10);
        clk_slow = 1'b0; step(10);
        clk_slow = 1'b1; step(5);
        check("rst_hold_state", 32'(state), 32'd0);
        check("rst_hold_floor", 32'(floor), 32'd0);

        // Release with clk_slow high and call floor 0 at once: a spurious tick
        // after release would shorten the door interval below.
        reset = 1'b1;
        pulse_call(0);
        check("here_state", 32'(state), 32'd2);
        check("here_pend",  32'(req_pending), 32'h00);
        check("here_door",  32'(door_open), 32'd1);
        clk_slow = 1'b0;
        step(10);
        slow_tick();
        slow_tick();
        check("here_door_2tk", 32'(state), 32'd2);
        slow_tick();
        check("here_door_3tk", 32'(state), 32'd0);
        check("here_pend_end", 32'(req_pending), 32'h00);

        // Single call up 0 -> 3
        pulse_call(3);
        check("up_pend",  32'(req_pending), 32'h08);
        check("up_state", 32'(state), 32'd1);
        check("up_mov",   32'(moving), 32'd1);
        check("up_dir",   32'(dir_up), 32'd1);
        repeat (5) slow_tick();
        check("up_5tk_floor", 32'(floor), 32'd2);
        check("up_5tk_state", 32'(state), 32'd1);
        slow_tick();
        check("up_6tk_floor", 32'(floor), 32'd3);
        check("up_6tk_state", 32'(state), 32'd2);
        check("up_6tk_pend",  32'(req_pending), 32'h00);
        slow_tick();
        slow_tick();
        check("up_door_2tk", 32'(state), 32'd2);
        slow_tick();
        check("up_door_3tk", 32'(state), 32'd0);

        // SCAN: heading up to 6 from 3, call 2 while at 4
        pulse_call(6);
        check("scan_mv", 32'(state), 32'd1);
        slow_tick();
        slow_tick();
        check("scan_f4", 32'(floor), 32'd4);
        pulse_call(2);
        check("scan_pend", 32'(req_pending), 32'h44);
        check("scan_dir_up", 32'(dir_up), 32'd1);
        repeat (4) slow_tick();
        check("scan_f6",      32'(floor), 32'd6);
        check("scan_f6_door", 32'(state), 32'd2);
        check("scan_f6_pend", 32'(req_pending), 32'h04);
        repeat (3) slow_tick();
        check("scan_rev_state", 32'(state), 32'd1);
        check("scan_rev_dir",   32'(dir_up), 32'd0);
        repeat (7) slow_tick();
        check("scan_f3",       32'(floor), 32'd3);
        check("scan_f3_state", 32'(state), 32'd1);
        slow_tick();
        check("scan_f2",      32'(floor), 32'd2);
        check("scan_f2_door", 32'(state), 32'd2);
        check("scan_f2_pend", 32'(req_pending), 32'h00);
        repeat (3) slow_tick();
        check("scan_idle", 32'(state), 32'd0);
        check("scan_dir",  32'(dir_up), 32'd0);

        // Door hold at floor 2, with a call to 7 latched meanwhile
        pulse_call(2);
        check("hold_open", 32'(state), 32'd2);
        check("hold_pend0", 32'(req_pending), 32'h00);
        slow_tick();
        pulse_call(7);
        check("hold_other_pend", 32'(req_pending), 32'h80);
        slow_tick();
        pulse_call(2);
        check("hold_absorb", 32'(req_pending), 32'h80);
        check("hold_still",  32'(state), 32'd2);
`ifdef LIFT_DOOR_HOLD_EN
        slow_tick();
        slow_tick();
        check("hold_ext_door", 32'(door_open), 32'd1);
        slow_tick();
`else
        slow_tick();
`endif
        check("hold_closed", 32'(door_open), 32'd0);
        check("hold_to_move", 32'(state), 32'd1);
        check("hold_dir", 32'(dir_up), 32'd1);

        // Travel 2 -> 5 toward 7, then reset mid-move
        repeat (6) slow_tick();
        check("mv_f5",       32'(floor), 32'd5);
        check("mv_f5_state", 32'(state), 32'd1);
        reset = 1'b0;
        #2;
        check("arst_state", 32'(state), 32'd0);
        check("arst_floor", 32'(floor), 32'd0);
        check("arst_dir",   32'(dir_up), 32'd1);
        check("arst_pend",  32'(req_pending), 32'h00);
        check("arst_mov",   32'(moving), 32'd0);
        check("arst_door",  32'(door_open), 32'd0);
        step(2);
        reset = 1'b1;
        step(3);
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_floor", 32'(floor), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
